// File: rtl/magnitude_averager.sv
// Windowed mean/peak/min of the CORDIC magnitude stream, one result
// per 2^LOG2_AVG_LEN accepted samples.
module magnitude_averager #(
    parameter int MAG_WIDTH    = 33,
    parameter int LOG2_AVG_LEN = 10
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_valid,
    input  logic [MAG_WIDTH-1:0]    i_magnitude,
    input  logic                    i_clear,
    output logic                    o_valid,
    output logic [MAG_WIDTH-1:0]    o_mean,
    output logic [MAG_WIDTH-1:0]    o_peak,
    output logic [MAG_WIDTH-1:0]    o_min,
    output logic [31:0]             o_window_count
);

    localparam int ACC_W = MAG_WIDTH + LOG2_AVG_LEN;
    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (LOG2_AVG_LEN - 1);

    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_next;
    logic [ACC_W-1:0]        sum_rnd;
    logic [LOG2_AVG_LEN-1:0] cnt;
    logic [MAG_WIDTH-1:0]    peak;
    logic [MAG_WIDTH-1:0]    min_v;
    logic [MAG_WIDTH-1:0]    peak_next;
    logic [MAG_WIDTH-1:0]    min_next;
    logic                    last;

    // Full window plus half-LSB never exceeds 2^ACC_W - 1.
    always_comb begin
        acc_next  = acc + {{LOG2_AVG_LEN{1'b0}}, i_magnitude};
        sum_rnd   = acc_next + HALF;
        peak_next = (i_magnitude > peak) ? i_magnitude : peak;
        min_next  = (i_magnitude < min_v) ? i_magnitude : min_v;
        last      = &cnt;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc            <= '0;
            cnt            <= '0;
            peak           <= '0;
            min_v          <= '1;
            o_valid        <= 1'b0;
            o_mean         <= '0;
            o_peak         <= '0;
            o_min          <= '0;
            o_window_count <= '0;
        end else begin
            o_valid <= 1'b0;
            if (i_clear) begin
                acc   <= '0;
                cnt   <= '0;
                peak  <= '0;
                min_v <= '1;
            end else if (i_valid) begin
                if (last) begin
                    o_valid        <= 1'b1;
                    o_mean         <= sum_rnd[ACC_W-1:LOG2_AVG_LEN];
                    o_peak         <= peak_next;
                    o_min          <= min_next;
                    o_window_count <= o_window_count + 32'd1;
                    acc            <= '0;
                    cnt            <= '0;
                    peak           <= '0;
                    min_v          <= '1;
                end else begin
                    acc   <= acc_next;
                    cnt   <= cnt + 1'b1;
                    peak  <= peak_next;
                    min_v <= min_next;
                end
            end
        end
    end

endmodule

// File: doc/magnitude_averager.md
Name: magnitude_averager

Overview:
- Sits directly downstream of magnitude_finder in the DPM chain.
- Consumes the stream of unsigned CORDIC magnitude samples and accumulates them over a fixed window of 2^LOG2_AVG_LEN valid samples.
- At the end of each window, emits one result: rounded mean, peak and minimum magnitude.
- Performs no CORDIC-gain compensation; scaling to dBm is done further downstream.

Parameters:
- MAG_WIDTH, 33: width of the unsigned input magnitude (INPUT_DATA_WIDTH+1 of the upstream stage).
- LOG2_AVG_LEN, 10: window length is 2^LOG2_AVG_LEN valid samples; legal range 1..20.

Ports:
- i_clk  input  1  system clock; all logic is on the rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_valid  input  1  i_magnitude is valid this cycle.
- i_magnitude  input  MAG_WIDTH  unsigned magnitude sample.
- i_clear  input  1  synchronous soft restart of the current window.
- o_valid  output  1  one-cycle pulse: result outputs updated.
- o_mean  output  MAG_WIDTH  rounded mean of the last completed window.
- o_peak  output  MAG_WIDTH  maximum sample of the last completed window.
- o_min  output  MAG_WIDTH  minimum sample of the last completed window.
- o_window_count  output  32  completed windows since reset, wrapping modulo 2^32.

Behaviour:
- Reset values (i_reset high at a clock edge):
  - o_valid=0; o_mean, o_peak, o_min and o_window_count = 0.
  - Internal accumulator=0, sample counter=0, running peak=0, running min=all-ones.
  - Reset takes priority over every other input.
- Internal state:
  - Accumulator width is MAG_WIDTH+LOG2_AVG_LEN. It cannot overflow, including the rounding term.
  - Sample counter width is LOG2_AVG_LEN.
- Sample acceptance: a sample is accepted on any edge with i_valid=1 and i_reset=0 and i_clear=0. There is no backpressure; every valid sample is taken.
- Mid-window accept (counter != 2^N-1):
  - acc += sample; counter++.
  - Running peak = max(peak, sample); running min = min(min, sample).
- Final accept (counter == 2^N-1), on the same edge:
  - o_mean = (acc + sample + 2^(N-1)) >> N, i.e. round-half-up. The result always fits MAG_WIDTH, so no saturation logic is needed.
  - o_peak and o_min = max/min including this sample.
  - o_valid=1 for exactly that one following cycle; o_window_count++.
  - Accumulator, counter, peak and min reload to 0, 0, 0 and all-ones. The next valid sample on the following cycle starts a new window with no gap.
- Result timing:
  - Latency from the final sample edge to o_valid high is 1 cycle.
  - Result outputs hold their values until the next window completes.
  - o_valid is 0 on every other cycle.
- Gaps: i_valid low cycles are ignored and the counter holds. Window length counts valid samples, not cycles.
- i_clear:
  - Discards the partial window: accumulator, counter, peak and min reload as above.
  - A sample presented in the same cycle is discarded, so clear wins.
  - Result outputs and o_window_count are untouched; o_valid is 0 that cycle.
- Reset mid-window: the partial window is lost and all outputs return to reset values on the next edge.
- Minimum tracking uses an unsigned compare. The first sample of a window always replaces the all-ones min.

Test Plan:
- LOG2_AVG_LEN=2; 4 consecutive valid samples of 1646760 (the upstream magnitude for x=-600000, y=-800000) -> o_valid pulses once, 1 cycle after the 4th sample. Outputs: o_mean=o_peak=o_min=1646760, o_window_count=1.
- LOG2_AVG_LEN=2; samples 1,2,3,4 then 5,5,5,6 back-to-back -> first result: mean=3 ((10+2)>>2), peak=4, min=1. Second result arrives exactly 4 cycles later: mean=5 ((21+2)>>2), peak=6, min=5, count=2.
- LOG2_AVG_LEN=2; samples 7,?,9,?,?,11,13 where ? = i_valid low -> single o_valid, 1 cycle after sample 13. Outputs: mean=10, peak=13, min=7.
- LOG2_AVG_LEN=2; samples 100,200, then i_clear together with valid 999, then 1,1,1,1 -> 999 discarded; result mean=1, peak=1, min=1. The previous o_mean value is held until then.
- LOG2_AVG_LEN=2; 3 samples of 50, then i_reset for 1 cycle, then 4 samples of 8 -> outputs are 0 during and after reset. Result: mean=8, count=1.
- LOG2_AVG_LEN=2, MAG_WIDTH=33; 4 samples of 2^33-1 -> mean=2^33-1, peak=2^33-1, no wrap.
